// File: rtl/note_player.sv
// Note sequencer feeding the PWM dac: prescaled dac_clk, a mirror of the dac period
// counter, and a handshake FSM that swaps period/t_on only on dac period boundaries.
module note_player #(
  parameter int unsigned N        = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned DUR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_idx,
  input  logic [1:0]       note_vol,
  input  logic [DUR_W-1:0] note_dur,
  output logic             dac_clk,
  output logic [N-1:0]     period,
  output logic [N-1:0]     t_on,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    PLAY      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  cnt_q, cnt_d;
  logic             dac_clk_q, dac_clk_d;
  logic [N-1:0]     phase_q, phase_d;
  logic [N-1:0]     period_q, period_d;
  logic [N-1:0]     t_on_q, t_on_d;
  logic             note_ready_q, note_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       vol_q, vol_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             boundary;

  // Period register value per note index; dac cycle is value+1 ticks.
  function automatic logic [N-1:0] pitch_period(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:  v = 8'd255;
      4'd1:  v = 8'd238;
      4'd2:  v = 8'd224;
      4'd3:  v = 8'd212;
      4'd4:  v = 8'd200;
      4'd5:  v = 8'd189;
      4'd6:  v = 8'd178;
      4'd7:  v = 8'd168;
      4'd8:  v = 8'd158;
      4'd9:  v = 8'd149;
      4'd10: v = 8'd141;
      4'd11: v = 8'd133;
      4'd12: v = 8'd126;
      4'd13: v = 8'd118;
      4'd14: v = 8'd112;
      4'd15: v = 8'd105;
    endcase
    return N'(v);
  endfunction

  // High time as a fraction of the full cycle length; rests are always silent.
  function automatic logic [N-1:0] duty(input logic [3:0] idx, input logic [1:0] vol);
    logic [N:0] p;
    logic [N-1:0] r;
    p = {1'b0, pitch_period(idx)} + (N+1)'(1);
    case (vol)
      2'd3: r = N'(p >> 1);
      2'd2: r = N'(p >> 2);
      2'd1: r = N'(p >> 3);
      2'd0: r = '0;
    endcase
    if (idx == 4'd0) r = '0;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dac_clk_q    <= 1'b0;
      phase_q      <= '0;
      period_q     <= '0;
      t_on_q       <= '0;
      note_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      remaining_q  <= '0;
      idx_q        <= '0;
      vol_q        <= '0;
      dur_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dac_clk_q    <= dac_clk_d;
      phase_q      <= phase_d;
      period_q     <= period_d;
      t_on_q       <= t_on_d;
      note_ready_q <= note_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      vol_q        <= vol_d;
      dur_q        <= dur_d;
    end
  end

  // Prescaler and mirror of the dac period counter.
  always_comb begin
    cnt_d     = (cnt_q == PS_MAX) ? '0 : cnt_q + PS_W'(1);
    dac_clk_d = (cnt_q == PS_MAX);
    boundary  = dac_clk_q && (phase_q >= period_q);
    phase_d   = phase_q;
    if (dac_clk_q) begin
      phase_d = (phase_q >= period_q) ? '0 : phase_q + N'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    t_on_d       = t_on_q;
    note_ready_d = note_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    vol_d        = vol_q;
    dur_d        = dur_q;
    case (state_q)
      IDLE: begin
        t_on_d = '0;
        if (note_valid && note_ready_q) begin
          idx_d        = note_idx;
          vol_d        = note_vol;
          dur_d        = (note_dur == '0) ? DUR_W'(1) : note_dur;
          note_ready_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        // Loading on the boundary edge coincides with the dac counter returning to 0.
        if (boundary) begin
          period_d    = pitch_period(idx_q);
          t_on_d      = duty(idx_q, vol_q);
          remaining_d = dur_q;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (boundary) begin
          if (remaining_q == DUR_W'(1)) begin
            t_on_d       = '0;
            done_d       = 1'b1;
            note_ready_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            remaining_d = remaining_q - DUR_W'(1);
          end
        end
      end
      default: begin
        state_d      = IDLE;
        note_ready_d = 1'b1;
        busy_d       = 1'b0;
        t_on_d       = '0;
      end
    endcase
  end

  assign dac_clk    = dac_clk_q;
  assign period     = period_q;
  assign t_on       = t_on_q;
  assign note_ready = note_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
